// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// STATUS bit layout and the address-region decoder.
package dmem_pkg;

    localparam logic [3:0] MMIO_CYCLE  = 4'h0;
    localparam logic [3:0] MMIO_TXDATA = 4'h4;
    localparam logic [3:0] MMIO_STATUS = 4'h8;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_ERROR     = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {RAM, MMIO, UNMAPPED} region_t;

    // RAM takes priority; the I/O window is matched on its 16-byte block.
    function automatic region_t decode(input logic [31:0] addr,
                                       input int unsigned addr_w,
                                       input logic [31:0] base);
        if ((addr >> (addr_w + 32'd2)) == 32'd0)
            return RAM;
        else if (addr[31:4] == base[31:4])
            return MMIO;
        else
            return UNMAPPED;
    endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Byte-wide transmit FIFO with wrap-bit pointers; head is combinational from
// registered storage. A push while full is accepted only when a pop frees a slot.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, the slot being written is the one popped on this same edge.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port: byte-lane RAM plus an I/O window (cycle counter, TX FIFO,
// STATUS). Reads are combinational; writes and pushes land on the rising edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_t           region;
    logic [3:0]        mmio_off;
    logic [ADDR_W-1:0] word_idx;
    logic              unused_addr_lsbs;

    logic [31:0] ram [2**ADDR_W];
    logic [31:0] cycle_cnt;
    logic        overflow;
    logic        error;
    logic [31:0] status;

    logic          mmio_wr_lo;
    logic          push;
    logic          pop;
    logic          status_wr;
    logic          cycle_ld;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    assign region           = decode(mem_addr, ADDR_W, MMIO_BASE);
    assign mmio_off         = {mem_addr[3:2], 2'b00};
    assign word_idx         = mem_addr[ADDR_W+1:2];
    assign unused_addr_lsbs = ^mem_addr[1:0];

    assign mmio_wr_lo = en && (region == MMIO) && mem_write_en[0];
    assign push       = mmio_wr_lo && (mmio_off == MMIO_TXDATA);
    assign status_wr  = mmio_wr_lo && (mmio_off == MMIO_STATUS);
    assign cycle_ld   = en && (region == MMIO) && (mmio_off == MMIO_CYCLE) && (mem_write_en == 4'b1111);
    assign pop        = tx_valid && tx_ready;

    tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_write_data[7:0]),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;

    // Lane 3 carries the lowest byte address (big-endian).
    always_ff @(posedge clk) begin
        if (en && (region == RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_write_en[i]) ram[word_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (cycle_ld)
                cycle_cnt <= mem_write_data;
            else if (en)
                cycle_cnt <= cycle_cnt + 32'd1;

            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (status_wr && mem_write_data[ST_OVERFLOW])
                overflow <= 1'b0;

            if (en && (region == UNMAPPED) && ((|mem_write_en) || mem_read_en))
                error <= 1'b1;
            else if (status_wr && mem_write_data[ST_ERROR])
                error <= 1'b0;
        end
    end

    always_comb begin
        status                      = '0;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_FULL]             = fifo_full;
        status[ST_OVERFLOW]         = overflow;
        status[ST_ERROR]            = error;
        status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_read_en) begin
            case (region)
                RAM:  mem_read_data = ram[word_idx];
                MMIO: begin
                    if (mmio_off == MMIO_CYCLE)       mem_read_data = cycle_cnt;
                    else if (mmio_off == MMIO_STATUS) mem_read_data = status;
                end
                default: mem_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a byte/queue-level model.
module tb_dmem_responder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  mem_write_en = 4'h0;
    logic        mem_read_en = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [31:0] mem_read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int total = 0;
    int bad = 0;
    bit run_chk = 1'b0;

    // Model state: byte-addressed RAM, plain counter, byte queue, sticky flags.
    logic [7:0]  mram [int];
    int unsigned m_cycle = 0;
    logic [7:0]  q [$];
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;

    dmem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a < 32'h0000_1000) return 0;
        if ((a & 32'hFFFF_FFF0) == 32'hFFFF_0000) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(q.size()), 4'h0, m_err, m_ovf, q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic bit exp_read(output logic [31:0] v);
        int base;
        v = 32'h0;
        if (!mem_read_en) return 1'b1;
        case (region(mem_addr))
            0: begin
                base = int'(mem_addr & 32'h0000_0FFC);
                for (int k = 0; k < 4; k++)
                    if (!mram.exists(base + k)) return 1'b0;
                v = {mram[base], mram[base+1], mram[base+2], mram[base+3]};
            end
            1: begin
                if (mem_addr[3:2] == 2'd0) v = m_cycle;
                else if (mem_addr[3:2] == 2'd2) v = m_status();
            end
            default: v = 32'h0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_step();
        int  r;
        bit  pop;
        r   = region(mem_addr);
        pop = (q.size() > 0) && tx_ready;
        if (pop) void'(q.pop_front());
        if (en) begin
            if (r == 0)
                for (int k = 0; k < 4; k++)
                    if (mem_write_en[k]) mram[int'(mem_addr & 32'h0000_0FFC) + (3 - k)] = mem_write_data[8*k +: 8];
            if (r == 1 && mem_addr[3:2] == 2'd0 && mem_write_en == 4'hF) m_cycle = mem_write_data;
            else m_cycle++;
            if (r == 1 && mem_addr[3:2] == 2'd1 && mem_write_en[0]) begin
                if (q.size() < DEPTH) q.push_back(mem_write_data[7:0]);
                else m_ovf = 1'b1;
            end
            if (r == 1 && mem_addr[3:2] == 2'd2 && mem_write_en[0]) begin
                if (mem_write_data[2]) m_ovf = 1'b0;
                if (mem_write_data[3]) m_err = 1'b0;
            end
            if (r == 2 && ((|mem_write_en) || mem_read_en)) m_err = 1'b1;
        end
    endtask

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge rst_n) begin
        q.delete();
        m_cycle = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
    end

    always @(negedge clk) begin
        logic [31:0] v;
        if (run_chk) begin
            if (exp_read(v)) chk("rdata", mem_read_data, v);
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() > 0});
            chk("tx_data", {24'b0, tx_data}, (q.size() > 0) ? {24'b0, q[0]} : 32'h0);
        end
    end

    task automatic set_in(input bit e, input logic [3:0] we, input bit rd,
                          input logic [31:0] a, input logic [31:0] d, input bit rdy);
        en = e; mem_write_en = we; mem_read_en = rd;
        mem_addr = a; mem_write_data = d; tx_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal check of both the DUT and the model at the next sampling point.
    task automatic lit(input string n, input logic [31:0] exp);
        logic [31:0] v;
        @(negedge clk);
        chk(n, mem_read_data, exp);
        if (exp_read(v)) chk({"model_", n}, v, exp);
    endtask

    initial begin
        set_in(0, 4'h0, 1, 32'hFFFF_0008, 0, 0);
        run_chk = 1'b1;
        #1 rst_n = 1'b0;
        lit("reset_status", 32'h1);
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        set_in(1, 4'h0, 0, 0, 0, 0);
        repeat (5) tick();
        set_in(0, 4'h0, 0, 0, 0, 0);
        repeat (3) tick();
        set_in(0, 4'h0, 1, 32'hFFFF_0000, 0, 0);
        lit("cycle_5", 32'd5);
        tick();

        set_in(1, 4'hF, 0, 32'h10, 32'hCAFE_F00D, 0); tick();
        set_in(1, 4'hF, 1, 32'h10, 32'h1122_3344, 0);
        lit("ram_same_cycle_old", 32'hCAFE_F00D); tick();
        set_in(1, 4'b0010, 0, 32'h12, 32'hAAAA_AAAA, 0); tick();
        set_in(1, 4'h0, 1, 32'h10, 0, 0);
        lit("ram_byte_lane", 32'h1122_AA44); tick();

        set_in(1, 4'hF, 0, 32'h20, 32'h0, 0); tick();
        set_in(1, 4'b0011, 0, 32'h22, 32'hBEEF_BEEF, 0); tick();
        set_in(1, 4'h0, 1, 32'h20, 0, 0);
        lit("ram_halfword", 32'h0000_BEEF); tick();

        set_in(1, 4'hF, 0, 32'hFFFF_0000, 32'hFFFF_FFFF, 0); tick();
        set_in(1, 4'h0, 1, 32'hFFFF_0000, 0, 0);
        lit("cycle_load", 32'hFFFF_FFFF); tick();
        lit("cycle_wrap", 32'h0); tick();

        for (int i = 1; i <= 9; i++) begin
            set_in(1, 4'b0001, 0, 32'hFFFF_0004, i, 0); tick();
        end
        set_in(1, 4'h0, 1, 32'hFFFF_0008, 0, 0);
        lit("status_full_ovf", 32'h0000_0806); tick();
        set_in(0, 4'h0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("drain_order", {24'b0, tx_data}, i);
            tick();
        end
        @(negedge clk);
        chk("drained_valid", {31'b0, tx_valid}, 32'h0);
        set_in(1, 4'b0001, 0, 32'hFFFF_0008, 32'h4, 0); tick();
        set_in(1, 4'h0, 1, 32'hFFFF_0008, 0, 0);
        lit("ovf_cleared", 32'h1); tick();

        for (int i = 0; i < 8; i++) begin
            set_in(1, 4'b0001, 0, 32'hFFFF_0004, 32'hA0 + i, 0); tick();
        end
        set_in(1, 4'b0001, 0, 32'hFFFF_0004, 32'h55, 1); tick();
        set_in(0, 4'h0, 1, 32'hFFFF_0008, 0, 0);
        lit("full_push_pop", 32'h0000_0802); tick();
        set_in(0, 4'h0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("push_pop_order", {24'b0, tx_data}, (i < 8) ? 32'hA0 + i : 32'h55);
            tick();
        end

        set_in(1, 4'hF, 0, 32'h8000_0000, 32'hDEAD_BEEF, 0); tick();
        set_in(1, 4'h0, 1, 32'h8000_0000, 0, 0);
        lit("unmapped_read", 32'h0); tick();
        set_in(1, 4'h0, 1, 32'hFFFF_0008, 0, 0);
        lit("status_error", 32'h0000_0009); tick();

        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'b0001, 0, 32'hFFFF_0004, 32'h30 + i, 0); tick();
        end
        set_in(0, 4'h0, 1, 32'hFFFF_0008, 0, 1); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("midreset_status", mem_read_data, 32'h1);
        tick(); tick();
        rst_n = 1'b1;

        for (int w = 0; w < 16; w++) begin
            set_in(1, 4'hF, 0, w * 4, $urandom, 0); tick();
        end
        set_in(1, 4'hF, 0, 32'hFFC, $urandom, 0); tick();

        repeat (3000) begin
            int          kind;
            logic [31:0] a;
            logic [3:0]  we;
            kind = $urandom_range(0, 9);
            if (kind <= 4)      a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            else if (kind <= 7) a = 32'hFFFF_0000 + $urandom_range(0, 15);
            else if (kind == 8) a = 32'h8000_0000 | $urandom_range(0, 255);
            else                a = 32'hFFC + $urandom_range(0, 3);
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            set_in($urandom_range(0, 7) != 0, we, $urandom_range(0, 1) == 1, a, $urandom,
                   $urandom_range(0, 2) == 0);
            tick();
        end

        set_in(0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core's memory port. It serves word, halfword and byte stores through big-endian byte enables and returns read data in the same cycle. It backs a word-addressed RAM and a small memory-mapped I/O window holding a cycle counter and a byte-wide transmit FIFO with a valid/ready drain port. It sits beside the core at top level, and the core's MEM-stage port connects straight to it.

## Interface
- ADDR_W, 10: RAM word-index width (2^ADDR_W words).
- FIFO_DEPTH, 8: transmit FIFO entries (power of two, ≥2).
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte I/O window (16-byte aligned).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  core enable; gates RAM writes, FIFO pushes, register writes and counter.
- mem_write_en  in  4  byte-lane write enables; bit 3 = data[31:24] = lowest byte address.
- mem_read_en  in  1  read strobe.
- mem_addr  in  32  byte address; bits [1:0] ignored for selection.
- mem_write_data  in  32  lane-placed store data.
- mem_read_data  out  32  read word, combinational.
- tx_data  out  8  FIFO head byte; 0 when empty.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head when tx_valid & tx_ready.

## Operation
- Decode on word address mem_addr[31:2]:
  - RAM when mem_addr[31:ADDR_W+2]==0.
  - MMIO when mem_addr[31:4]==MMIO_BASE[31:4].
  - Otherwise unmapped.
- RAM write: lane i of word mem_addr[ADDR_W+1:2] written when en & mem_write_en[i]. Other lanes unchanged. RAM is not reset.
- RAM read: mem_read_data = stored word when mem_read_en. A same-cycle write to the same word returns old data.
- mem_read_data = 0 when mem_read_en=0, for unmapped reads, and for write-only/reserved MMIO regs.
- MMIO +0x0 CYCLE:
  - 32-bit counter, +1 per cycle while en, wraps FFFF_FFFF→0.
  - A write with mem_write_en==4'b1111 & en loads mem_write_data. The load wins over the increment.
  - Other partial writes are ignored.
- MMIO +0x4 TXDATA: en & mem_write_en[0] pushes mem_write_data[7:0]. Reads return 0.
- MMIO +0x8 STATUS (read):
  - [0] empty, [1] full, [2] overflow (sticky), [3] unmapped-access error (sticky).
  - [15:8] count. Other bits 0.
  - A write with en & mem_write_en[0] clears overflow if data[2]=1 and error if data[3]=1.
- MMIO +0xC: reserved, reads 0, writes ignored.
- Unmapped write (any lane, en) or unmapped read sets error.
- FIFO push and pop:
  - Push when full with no pop: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both take effect, count unchanged.
  - Pop ignores en; tx_ready has no effect when empty.
- Reset values: counter 0, FIFO empty, count 0, overflow 0, error 0, tx_valid 0, tx_data 0. mem_read_data follows inputs.
- Reset asserted mid-operation clears all state asynchronously. In-flight pushes and pops are discarded.

## Timing
- Read latency 0 cycles: mem_read_data is combinational from mem_addr/mem_read_en and state.
- A write at edge N is visible to a read in cycle N+1.
- Push at edge N: tx_valid and tx_data valid in cycle N+1. Pop at edge N: next head or empty in cycle N+1.
- STATUS reflects state after the previous edge. A push in the same cycle is not yet counted.
- Counter read in cycle N returns value before edge N. A load at edge N is read back in N+1 as the loaded value.
- en=0: no state change except FIFO pop and asynchronous reset.

## Structure
- Package dmem_pkg:
  - MMIO offsets: CYCLE 0x0, TXDATA 0x4, STATUS 0x8.
  - STATUS bit positions, and the region-decode enum {RAM, MMIO, UNMAPPED}.
- Sub-module tx_fifo:
  - Parameterised depth; push, pop, full, empty, count, head.
  - Pointers with wrap bit, registered storage.
- Top contains the decoder, RAM array, counter, sticky flags and read mux.

## Test plan
- RAM lanes: sw 0x11223344 to 0x10; sb 0xAA AA AA AA with en 4'b0010 to 0x12; lw 0x10 -> 0x1122AA44. A read in the same cycle as the sw returns the prior value.
- Halfword store: sh with data 0xBEEF_BEEF, en 4'b0011 to 0x22 over 0x00000000 -> lw 0x20 = 0x0000BEEF.
- FIFO: tx_ready=0; push 9 bytes 0x01..0x09 (depth 8) -> STATUS = 0x0000_0806 (count 8, full, overflow). Drain with tx_ready=1 -> bytes 01..08 in order, then tx_valid=0. Write STATUS data 0x4 -> overflow 0.
- Full push+pop: full FIFO, push 0x55 with tx_ready=1 same cycle -> count stays 8, 0x55 emerges last.
- Counter: after reset, 5 cycles en=1 then 3 cycles en=0 -> CYCLE reads 5. Load 0xFFFF_FFFF -> next cycle reads FFFF_FFFF, following cycle 0.
- Unmapped/reset: write 0x8000_0000 -> STATUS[3]=1, read 0. Assert rst_n low mid-drain -> tx_valid 0, STATUS 0x0000_0001 immediately.
